// File: rtl/booth_controller.sv
// Moore control FSM for a radix-2 Booth multiplier datapath.
// Every output is a decode of the current state; the datapath owns A, Q, M, Q-1 and the bit counter.
module booth_controller #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic ldM,
  output logic ldQ,
  output logic clrA,
  output logic clrff,
  output logic ldcount,
  output logic ldA,
  output logic addsub,
  output logic sftA,
  output logic sftQ,
  output logic decr,
  output logic busy,
  output logic done
);

  // The iteration count lives in the datapath counter; the controller only checks it is sane.
  if (WIDTH < 1) begin : g_width_check
    $error("booth_controller: WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    EVAL   = 3'd3,
    ADD    = 3'd4,
    SUB    = 3'd5,
    SHIFT  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = start ? LOAD_M : IDLE;
        LOAD_M:  state_next = LOAD_Q;
        LOAD_Q:  state_next = EVAL;
        EVAL: begin
          // Counter exhaustion wins over the Booth pair.
          if (eqz) begin
            state_next = DONE;
          end else begin
            case ({q0, qm1})
              2'b01:   state_next = ADD;
              2'b10:   state_next = SUB;
              default: state_next = SHIFT;
            endcase
          end
        end
        ADD:     state_next = SHIFT;
        SUB:     state_next = SHIFT;
        SHIFT:   state_next = EVAL;
        // start must drop before another operation is accepted.
        DONE:    state_next = start ? DONE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ldM     = 1'b0;
    ldQ     = 1'b0;
    clrA    = 1'b0;
    clrff   = 1'b0;
    ldcount = 1'b0;
    ldA     = 1'b0;
    addsub  = 1'b0;
    sftA    = 1'b0;
    sftQ    = 1'b0;
    decr    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_reg)
      LOAD_M: begin
        ldM  = 1'b1;
        busy = 1'b1;
      end
      LOAD_Q: begin
        ldQ     = 1'b1;
        clrA    = 1'b1;
        clrff   = 1'b1;
        ldcount = 1'b1;
        busy    = 1'b1;
      end
      EVAL: begin
        busy = 1'b1;
      end
      ADD: begin
        ldA    = 1'b1;
        addsub = 1'b1;
        busy   = 1'b1;
      end
      SUB: begin
        ldA  = 1'b1;
        busy = 1'b1;
      end
      SHIFT: begin
        sftA = 1'b1;
        sftQ = 1'b1;
        decr = 1'b1;
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a small datapath closes the loop, and the expected control
// trace is derived from Booth recoding of the multiplier bits.
module tb_booth_controller;

  localparam int W = 16;

  localparam logic [11:0] V_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] V_LOADM = 12'b1000_0000_0010;
  localparam logic [11:0] V_LOADQ = 12'b0111_1000_0010;
  localparam logic [11:0] V_EVAL  = 12'b0000_0000_0010;
  localparam logic [11:0] V_ADD   = 12'b0000_0110_0010;
  localparam logic [11:0] V_SUB   = 12'b0000_0100_0010;
  localparam logic [11:0] V_SHIFT = 12'b0000_0001_1110;
  localparam logic [11:0] V_DONE  = 12'b0000_0000_0001;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic q0, qm1, eqz;
  logic ldM, ldQ, clrA, clrff, ldcount, ldA, addsub, sftA, sftQ, decr, busy, done;

  logic [15:0] a_r, q_r, m_r, m_in, q_in;
  logic        qm1_r;
  logic [4:0]  cnt_r;

  logic [11:0] outs;
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  assign outs = {ldM, ldQ, clrA, clrff, ldcount, ldA, addsub, sftA, sftQ, decr, busy, done};
  assign q0   = q_r[0];
  assign qm1  = qm1_r;
  assign eqz  = (cnt_r == 5'd0);

  booth_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .q0(q0), .qm1(qm1), .eqz(eqz),
    .ldM(ldM), .ldQ(ldQ), .clrA(clrA), .clrff(clrff), .ldcount(ldcount),
    .ldA(ldA), .addsub(addsub), .sftA(sftA), .sftQ(sftQ), .decr(decr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath environment reacting to the controller's strobes.
  always @(posedge clk) begin
    if (ldM) m_r <= m_in;
    if (ldQ) q_r <= q_in;
    if (clrA) a_r <= 16'd0;
    if (clrff) qm1_r <= 1'b0;
    if (ldcount) cnt_r <= 5'(W);
    if (ldA) a_r <= addsub ? a_r + m_r : a_r - m_r;
    if (sftA) a_r <= {a_r[15], a_r[15:1]};
    if (sftQ) begin
      q_r   <= {a_r[0], q_r[15:1]};
      qm1_r <= q_r[0];
    end
    if (decr) cnt_r <= cnt_r - 5'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic compare_loop();
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("trace", 32'(outs), 32'(e));
      end
    end
  endtask

  // Expected control sequence from Booth recoding of the multiplier.
  task automatic build_trace(input logic [15:0] q);
    logic prev;
    prev = 1'b0;
    exp_q.push_back(V_LOADM);
    exp_q.push_back(V_LOADQ);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(V_EVAL);
      if ({q[i], prev} == 2'b01) exp_q.push_back(V_ADD);
      if ({q[i], prev} == 2'b10) exp_q.push_back(V_SUB);
      exp_q.push_back(V_SHIFT);
      prev = q[i];
    end
    exp_q.push_back(V_EVAL);
    exp_q.push_back(V_DONE);
  endtask

  // Leaves start high and the DUT in DONE.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                        input int exp_edge, input logic [31:0] exp_prod);
    int edge_n;
    logic signed [31:0] model_prod;
    @(negedge clk); #1;
    m_in  = m;
    q_in  = q;
    start = 1'b1;
    build_trace(q);
    edge_n = 0;
    forever begin
      @(posedge clk); #1;
      if (done) break;
      edge_n++;
      if (edge_n > 200) begin
        check("done_timeout", 32'(edge_n), 32'(exp_edge));
        break;
      end
    end
    model_prod = $signed(m) * $signed(q);
    check("done_edge", 32'(edge_n), 32'(exp_edge));
    check("product_literal", {a_r, q_r}, exp_prod);
    check("product_model", {a_r, q_r}, model_prod);
    $display("run M=%h Q=%h done after edge %0d product=%h", m, q, edge_n, {a_r, q_r});
  endtask

  task automatic hold_then_release();
    repeat (3) begin
      @(posedge clk); #1;
      check("held_done", 32'(done), 32'd1);
      check("held_busy", 32'(busy), 32'd0);
    end
    @(negedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("release_idle", 32'(outs), 32'(V_IDLE));
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    m_in = '0; q_in = '0;
    fork compare_loop(); join_none
    #1;
    check("reset_outs", 32'(outs), 32'(V_IDLE));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(outs), 32'(V_IDLE));

    run_op(16'd7, 16'h0000, 35, 32'h0000_0000);
    hold_then_release();
    run_op(16'd7, 16'hFFFF, 36, 32'hFFFF_FFF9);
    hold_then_release();
    run_op(16'hFFFB, 16'h0001, 37, 32'hFFFF_FFFB);
    hold_then_release();
    run_op(16'd3, 16'h5555, 51, 32'h0000_FFFF);
    repeat (2) begin
      @(posedge clk); #1;
      check("held_done", 32'(done), 32'd1);
    end

    // abort in DONE with start still high, then abort in IDLE with start high
    @(negedge clk); #1 abort = 1'b1;
    @(posedge clk); #1;
    check("abort_done_idle", 32'(outs), 32'(V_IDLE));
    @(posedge clk); #1;
    check("abort_idle_hold", 32'(outs), 32'(V_IDLE));
    @(negedge clk); #1 abort = 1'b0;
    @(posedge clk); #1;
    check("restart_level", 32'(outs), 32'(V_LOADM));
    @(negedge clk); #1 abort = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("abort_loadm", 32'(outs), 32'(V_IDLE));
    @(negedge clk); #1 abort = 1'b0;

    // abort in SUB
    m_in = 16'd7; q_in = 16'hFFFF;
    start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (outs !== V_SUB && guard < 10);
    check("reach_sub", 32'(outs), 32'(V_SUB));
    @(negedge clk); #1 abort = 1'b1;
    @(posedge clk); #1;
    check("abort_sub_busy", 32'(busy), 32'd0);
    check("abort_sub_ldA", 32'(ldA), 32'd0);
    check("abort_sub_decr", 32'(decr), 32'd0);
    check("abort_sub_outs", 32'(outs), 32'(V_IDLE));
    @(negedge clk); #1 abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("after_abort_idle", 32'(outs), 32'(V_IDLE));

    // asynchronous reset in each busy state (LOAD_M..SHIFT, second EVAL, ADD, SHIFT)
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      m_in = 16'd5; q_in = 16'h0001; start = 1'b1;
      repeat (k) @(posedge clk);
      #1 check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outs", 32'(outs), 32'(V_IDLE));
      start = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
    end
    run_op(16'd3, 16'h5555, 51, 32'h0000_FFFF);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check("async_reset_done", 32'(outs), 32'(V_IDLE));
    start = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(outs), 32'(V_IDLE));
    check("trace_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
